datamem_responder: RTL

//  Memory-side responder for load/store requests issued by the execute stage.

---
 rtl/datamem_responder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/datamem_responder.sv
// datamem_responder
//   Handshaked, fixed-latency data memory for load/store requests from the
//   execute stage. Byte/half/word little-endian accesses with sign or zero
//   extension on loads and alignment checking. Serves one transaction at a time.
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   req_valid/ready  request handshake; ready only while idle
//   req_write        1 = store, 0 = load
//   req_type         00 byte, 01 half, 10 word, 11 illegal
//   req_sign_ext     loads: sign-extend (1) or zero-extend (0)
//   req_addr         byte address; low ADDR_WIDTH bits used, wraps
//   req_wdata        store data (low byte/half for sub-word stores)
//   resp_valid/ready response handshake
//   resp_rdata       load result; 0 for stores and errors
//   resp_err         misaligned access or illegal type
module datamem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_type,
    input  logic                  req_sign_ext,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    logic [1:0]              type_q, type_d;
    logic                    sext_q, sext_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [7:0]              mem [2**ADDR_WIDTH];
    logic                    mem_we;
    logic                    misaligned;
    logic [ADDR_WIDTH-1:0]   a1, a2, a3;
    logic [7:0]              b0, b1, b2, b3;
    logic [DATA_WIDTH-1:0]   load_val;
    logic                    addr_unused;

    assign addr_unused = ^req_addr[DATA_WIDTH-1:ADDR_WIDTH];

    assign req_ready  = (state_q == IDLE) && rst_n;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Byte lanes, wrapping modulo the array size.
    always_comb begin
        a1 = addr_q + ADDR_WIDTH'(1);
        a2 = addr_q + ADDR_WIDTH'(2);
        a3 = addr_q + ADDR_WIDTH'(3);
        b0 = mem[addr_q];
        b1 = mem[a1];
        b2 = mem[a2];
        b3 = mem[a3];
    end

    always_comb begin
        misaligned = 1'b0;
        case (type_q)
            2'b01:   misaligned = addr_q[0];
            2'b10:   misaligned = (addr_q[1:0] != 2'b00);
            2'b11:   misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    // Fill with ones first when sign-extending a negative field, then
    // overlay the loaded bytes.
    always_comb begin
        load_val = '0;
        case (type_q)
            2'b00: begin
                if (sext_q && b0[7]) load_val = '1;
                load_val[7:0] = b0;
            end
            2'b01: begin
                if (sext_q && b1[7]) load_val = '1;
                load_val[15:0] = {b1, b0};
            end
            2'b10:   load_val[31:0] = {b3, b2, b1, b0};
            default: load_val = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        type_d  = type_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    type_d  = req_type;
                    sext_d  = req_sign_ext;
                    addr_d  = req_addr[ADDR_WIDTH-1:0];
                    wdata_d = req_wdata;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    err_d   = misaligned;
                    rdata_d = (wr_q || misaligned) ? '0 : load_val;
                    mem_we  = wr_q && !misaligned;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            type_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            type_q  <= type_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is not reset. A reset forces state_q to IDLE, which drops
    // mem_we, so a store still in WAIT is never committed.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q[7:0];
            if (type_q != 2'b00) mem[a1] <= wdata_q[15:8];
            if (type_q == 2'b10) begin
                mem[a2] <= wdata_q[23:16];
                mem[a3] <= wdata_q[31:24];
            end
        end
    end

endmodule
